sha_msg_schedule: RTL
=====================

# sha_msg_schedule

Parametrised, streaming SHA-2 message-schedule generator. Accepts one 16-word message block over a valid/ready input and emits the full expanded schedule W[0..ROUNDS-1] over a valid/ready output, one word per cycle. It sits between the block-padding/feed logic and the round core. It generalises the fixed 32-bit σ0/σ1 functions to SHA-256 or SHA-512 word sizes with a configurable round count.

## Interface
- WORD_W, 32, word width; 32 selects SHA-256 sigmas, 64 selects SHA-512 sigmas; other values illegal.
- ROUNDS, 64, number of schedule words emitted per block; legal range 16..127 (80 for SHA-512).

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; discards the current block and returns to LOAD.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts a word.
- in_word  in  WORD_W  message word; big-endian word order, W[0] first.
- out_valid  out  1  out_word/out_idx are valid.
- out_ready  in  1  consumer accepts the word.
- out_word  out  WORD_W  schedule word W[out_idx].
- out_idx  out  7  schedule index t, 0..ROUNDS-1.
- out_last  out  1  high with out_valid when out_idx == ROUNDS-1.

## Operation
- Window: 16×WORD_W shift register w[0..15], w[0] oldest.
- Sigmas:
  - WORD_W=32: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
- Next word: nxt = σ1(w[14]) + w[9] + σ0(w[1]) + w[0], modulo 2^WORD_W. Carries are discarded.
- States:
  - LOAD: in_ready=1, out_valid=0. Each in handshake shifts in_word into w[15] and increments load count lc (0..15). On the handshake with lc==15, go to EMIT with out_idx=0.
  - EMIT: in_ready=0, out_valid=1, out_word=w[0]. Each out handshake shifts the window (w[i]←w[i+1], w[15]←nxt) and increments out_idx. The handshake with out_idx==ROUNDS-1 returns to LOAD and clears lc and out_idx.
- Stall: in EMIT with out_ready=0, out_word/out_idx/out_last hold stable.
- flush: highest priority after rst. Next state is LOAD with lc=0 and out_idx=0. Window contents are don't-care. A handshake in the same cycle as flush is discarded.
- in_valid during EMIT is ignored (in_ready=0); no word is consumed.

## Timing
- Reset values: in_ready=1, out_valid=0, out_word=0, out_idx=0, out_last=0, state LOAD, lc=0, window cleared.
- First out_valid appears the cycle after the 16th input handshake (1-cycle load→emit latency).
- Throughput: 1 word/cycle in each phase with no bubbles. One block takes 16 + ROUNDS cycles at full rate. LOAD re-opens the cycle after the last out handshake.
- out_word is registered; nxt is a single-cycle combinational path (3-input XOR ×2 plus a 4-operand add).
- in_ready and out_valid are decoded directly from the state register; no combinational path from out_ready or in_valid to any output.
- rst mid-block: outputs take reset values asynchronously and the partial block is lost.

## Configuration
- SHA_SCHED_BLKCNT_EN defined: adds output port blk_cnt[15:0].
  - Reset value 0.
  - Increments on each out handshake with out_last=1; wraps 0xFFFF→0.
  - Unaffected by flush.
- SHA_SCHED_BLKCNT_EN undefined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- SHA-256 "abc", WORD_W=32, ROUNDS=64: in W0=0x61626380, W1..14=0, W15=0x00000018, out_ready=1. Expect out words 0..15 equal inputs, W16=0x61626380, W17=0x000F0000, 64 words total, out_last only at idx 63. All values must match the reference model.
- Back-pressure: same block with out_ready toggling pseudo-randomly. Identical word sequence, out_word stable while stalled, in_ready=0 throughout EMIT.
- Back-to-back blocks: in_valid held high across two blocks. in_ready drops for exactly 64 emit cycles and re-asserts the cycle after idx 63 is accepted. Second block's schedule matches the model; blk_cnt=2 with SHA_SCHED_BLKCNT_EN.
- flush at out_idx=20: next cycle out_valid=0, in_ready=1. A fresh block then yields a correct schedule starting at idx 0.
- WORD_W=64, ROUNDS=80, SHA-512 "abc": W0=0x6162638000000000, W15=0x18. W16=0x6162638000000000 and W17=σ1(0x18) per the model. 80 words emitted.
- Async rst asserted mid-LOAD (after 7 words) and mid-EMIT. Outputs reach reset values without a clock edge; the next block loads from lc=0.

Source files
------------

// File: rtl/sha_msg_schedule.sv
// Streaming SHA-256/SHA-512 message-schedule generator: loads 16 words, emits W[0..ROUNDS-1].
// Optional feature macro SHA_SCHED_BLKCNT_EN adds the blk_cnt completed-block counter port.
module sha_msg_schedule #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [6:0]        out_idx,
    output logic              out_last
`ifdef SHA_SCHED_BLKCNT_EN
    ,
    output logic [15:0]       blk_cnt
`endif
);

    localparam logic [6:0]  LAST_IDX = 7'(ROUNDS - 1);
    localparam int unsigned S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int unsigned S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int unsigned S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int unsigned S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int unsigned S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int unsigned S1_SH = (WORD_W == 64) ? 6  : 10;

    typedef enum logic {ST_LOAD, ST_EMIT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_win [16];
    logic [3:0]        r_lc;
    logic [6:0]        r_idx;
    logic              w_in_hs;
    logic              w_out_hs;
    logic [WORD_W-1:0] w_nxt;
    logic [WORD_W-1:0] w_shift_in;

    function automatic logic [WORD_W-1:0] f_rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] f_sig0(input logic [WORD_W-1:0] x);
        return f_rotr(x, S0_R1) ^ f_rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] f_sig1(input logic [WORD_W-1:0] x);
        return f_rotr(x, S1_R1) ^ f_rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    assign in_ready   = (r_state == ST_LOAD);
    assign out_valid  = (r_state == ST_EMIT);
    assign out_word   = r_win[0];
    assign out_idx    = r_idx;
    assign out_last   = out_valid && (r_idx == LAST_IDX);
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;
    assign w_nxt      = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];
    assign w_shift_in = w_in_hs ? in_word : w_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: if (w_in_hs && (r_lc == 4'd15))       w_state_nxt = ST_EMIT;
                ST_EMIT: if (w_out_hs && (r_idx == LAST_IDX)) w_state_nxt = ST_LOAD;
                default: w_state_nxt = ST_LOAD;
            endcase
        end
    end

    // Load and emit share one shift path; the handshakes are exclusive by state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) r_win[i] <= '0;
            r_lc  <= '0;
            r_idx <= '0;
        end else if (flush) begin
            r_lc  <= '0;
            r_idx <= '0;
        end else if (w_in_hs || w_out_hs) begin
            for (int unsigned i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_shift_in;
            if (w_in_hs) r_lc <= r_lc + 4'd1;
            if (w_out_hs) r_idx <= (r_idx == LAST_IDX) ? 7'd0 : r_idx + 7'd1;
        end
    end

`ifdef SHA_SCHED_BLKCNT_EN
    logic [15:0] r_blk_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_blk_cnt <= '0;
        else if (!flush && w_out_hs && out_last) r_blk_cnt <= r_blk_cnt + 16'd1;
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule
